bcd_operand_entry: RTL

BCD_OPERAND_ENTRY -- requirements
Module: bcd_operand_entry

---
 rtl/bcd_operand_entry_pkg.sv | 29 ++
 rtl/bcd_operand_entry_key_sync_edge.sv | 53 +++++
 rtl/bcd_operand_entry.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bcd_operand_entry_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bcd_operand_entry_pkg                                      |
// | Purpose : Shared key_code constants and entry_state encoding for the |
// |           BCD operand entry block.                                   |
// | Ports   : none (package)                                             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bcd_operand_entry_pkg;

  // Codes 0x0-0x9 are digits; 0xE-0xF are invalid.
  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_PLUS      = 4'hA;
  localparam logic [3:0] KEY_MINUS     = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hC;
  localparam logic [3:0] KEY_CLEAR     = 4'hD;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_DONE    = 2'd2
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= KEY_MAX_DIGIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_operand_entry_key_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : key_sync_edge                                              |
// | Purpose : Synchronises the asynchronous key strobe and produces a    |
// |           one-cycle event on each synchronised rising edge.          |
// | Ports   : clk        - clock                                         |
// |           rst_n      - asynchronous active-low reset                 |
// |           key_strobe - raw asynchronous key-press level              |
// |           key_event  - one-cycle pulse per strobe rising edge        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module key_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_strobe,
  output logic key_event
);

  // After reset the chain holds zeros, which would look like a rising edge
  // if the strobe is already high. Events stay suppressed until both the
  // chain output and its delayed copy reflect real samples of the input.
  localparam int HOLD = SYNC_STAGES + 1;
  localparam int CW   = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;
  logic [CW-1:0]          holdoff_cnt;
  logic                   armed;

  assign armed = (holdoff_cnt == HOLD_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      level_d     <= 1'b0;
      holdoff_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_strobe};
      level_d <= sync_q[SYNC_STAGES-1];
      if (!armed) begin
        holdoff_cnt <= holdoff_cnt + CNT_ONE;
      end
    end
  end

  assign key_event = armed & sync_q[SYNC_STAGES-1] & ~level_d;

endmodule
`default_nettype wire

// File: rtl/bcd_operand_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bcd_operand_entry                                          |
// | Purpose : Keypad front end collecting two 2-digit BCD operands and   |
// |           an add/subtract operator for a downstream BCD ALU.         |
// | Ports   : clk, rst_n         - clock, async active-low reset         |
// |           key_strobe         - asynchronous key-press level          |
// |           key_code[3:0]      - 0-9 digit, A +, B -, C enter, D clear |
// |           in1_10/in1_1       - operand A tens/ones (BCD)             |
// |           in2_10/in2_1       - operand B tens/ones (BCD)             |
// |           operator           - 0 add, 1 subtract                     |
// |           operands_valid     - complete expression present (DONE)    |
// |           entry_state[1:0]   - 0 ENTER_A, 1 ENTER_B, 2 DONE          |
// |           key_err            - one-cycle pulse per rejected key      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bcd_operand_entry
  import bcd_operand_entry_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_strobe,
  input  logic [3:0] key_code,
  output logic [3:0] in1_10,
  output logic [3:0] in1_1,
  output logic [3:0] in2_10,
  output logic [3:0] in2_1,
  output logic       operator,
  output logic       operands_valid,
  output logic [1:0] entry_state,
  output logic       key_err
);

  entry_state_t state;
  logic [1:0]   count_a;
  logic [1:0]   count_b;
  logic         key_event;

  key_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_key_sync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_strobe (key_strobe),
    .key_event  (key_event)
  );

  assign entry_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_ENTER_A;
      in1_10         <= 4'd0;
      in1_1          <= 4'd0;
      in2_10         <= 4'd0;
      in2_1          <= 4'd0;
      count_a        <= 2'd0;
      count_b        <= 2'd0;
      operator       <= 1'b0;
      operands_valid <= 1'b0;
      key_err        <= 1'b0;
    end else begin
      key_err <= 1'b0;
      if (key_event) begin
        if (key_code == KEY_CLEAR) begin
          state          <= ST_ENTER_A;
          in1_10         <= 4'd0;
          in1_1          <= 4'd0;
          in2_10         <= 4'd0;
          in2_1          <= 4'd0;
          count_a        <= 2'd0;
          count_b        <= 2'd0;
          operator       <= 1'b0;
          operands_valid <= 1'b0;
        end else if (key_code > KEY_CLEAR) begin
          key_err <= 1'b1;
        end else begin
          case (state)
            ST_ENTER_A: begin
              if (is_digit(key_code)) begin
                if (count_a == 2'd2) begin
                  key_err <= 1'b1;
                end else begin
                  in1_10  <= in1_1;
                  in1_1   <= key_code;
                  count_a <= count_a + 2'd1;
                end
              end else if (key_code == KEY_ENTER || count_a == 2'd0) begin
                key_err <= 1'b1;
              end else begin
                operator <= (key_code == KEY_MINUS);
                state    <= ST_ENTER_B;
              end
            end

            ST_ENTER_B: begin
              if (is_digit(key_code)) begin
                if (count_b == 2'd2) begin
                  key_err <= 1'b1;
                end else begin
                  in2_10  <= in2_1;
                  in2_1   <= key_code;
                  count_b <= count_b + 2'd1;
                end
              end else if (key_code == KEY_ENTER) begin
                if (count_b == 2'd0) begin
                  key_err <= 1'b1;
                end else begin
                  state          <= ST_DONE;
                  operands_valid <= 1'b1;
                end
              end else if (count_b == 2'd0) begin
                // Operator may be changed until B has its first digit.
                operator <= (key_code == KEY_MINUS);
              end else begin
                key_err <= 1'b1;
              end
            end

            ST_DONE: begin
              // A digit starts a fresh expression with that digit in A.
              if (is_digit(key_code)) begin
                in1_10         <= 4'd0;
                in1_1          <= key_code;
                in2_10         <= 4'd0;
                in2_1          <= 4'd0;
                count_a        <= 2'd1;
                count_b        <= 2'd0;
                operator       <= 1'b0;
                operands_valid <= 1'b0;
                state          <= ST_ENTER_A;
              end else begin
                key_err <= 1'b1;
              end
            end

            default: begin
              state          <= ST_ENTER_A;
              operands_valid <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
